// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and width helpers for the convolution MAC engine.
package conv_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_WEIGHT_W = 32;
  localparam int DEF_K        = 5;
  localparam int DEF_NUM_CH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Index width for a range of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // Accumulator wide enough that K*K full-precision products cannot overflow.
  function automatic int acc_w(input int dw, input int ww, input int k);
    return dw + ww + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_dot_k.sv
// Combinational K*K signed dot product: window taps times one weight row, summed at ACC_W.
module conv_dot_k
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int K        = DEF_K,
  parameter int ACC_W    = acc_w(DATA_W, WEIGHT_W, K)
) (
  input  logic        [K*K*DATA_W-1:0]   win,
  input  logic        [K*K*WEIGHT_W-1:0] wrow,
  output logic signed [ACC_W-1:0]        sum
);

  localparam int TAPS   = K * K;
  localparam int PROD_W = DATA_W + WEIGHT_W;

  logic signed [ACC_W-1:0] prod_ext [TAPS];
  logic signed [ACC_W-1:0] acc;

  // Operands are widened before multiplying so each product keeps full precision.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod;
    assign a_ext        = PROD_W'($signed(win[gi*DATA_W +: DATA_W]));
    assign b_ext        = PROD_W'($signed(wrow[gi*WEIGHT_W +: WEIGHT_W]));
    assign prod         = a_ext * b_ext;
    assign prod_ext[gi] = ACC_W'(prod);
  end

  always_comb begin
    acc = '0;
    for (int t = 0; t < TAPS; t++) begin
      acc = acc + prod_ext[t];
    end
  end

  assign sum = acc;

endmodule

// File: rtl/conv_mac_engine.sv
// Time-multiplexed K*K convolution engine: one window in, one result per output channel out,
// using a writable per-channel weight memory and a single shared dot-product unit.
module conv_mac_engine
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int K        = DEF_K,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ACC_W    = acc_w(DATA_W, WEIGHT_W, K)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wt_we,
  input  logic [idx_w(NUM_CH)-1:0]       wt_ch,
  input  logic [idx_w(K*K)-1:0]          wt_idx,
  input  logic signed [WEIGHT_W-1:0]     wt_data,
  output logic                           wt_err,
  input  logic                           win_valid,
  output logic                           win_ready,
  input  logic [K*K*DATA_W-1:0]          win_data,
  input  logic                           relu_en,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [idx_w(NUM_CH)-1:0]       out_ch,
  output logic                           out_last,
  output logic signed [ACC_W-1:0]        out_data
);

  localparam int TAPS  = K * K;
  localparam int CH_W  = idx_w(NUM_CH);
  localparam int IDX_W = idx_w(TAPS);

  state_t                     state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [TAPS*DATA_W-1:0]     win_q, win_d;
  logic                       relu_q, relu_d;
  logic                       out_valid_q, out_valid_d;
  logic                       out_last_q, out_last_d;
  logic [CH_W-1:0]            out_ch_q, out_ch_d;
  logic signed [ACC_W-1:0]    out_data_q, out_data_d;
  logic                       wt_err_q, wt_err_d;
  logic                       pend_q, pend_d;
  logic [CH_W-1:0]            pend_ch_q, pend_ch_d;
  logic [IDX_W-1:0]           pend_idx_q, pend_idx_d;
  logic [WEIGHT_W-1:0]        pend_data_q, pend_data_d;
  logic [WEIGHT_W-1:0]        weights_q [NUM_CH][TAPS];
  logic [WEIGHT_W-1:0]        weights_d [NUM_CH][TAPS];

  logic                       in_range, accept, wr_ok, wr_now, wr_defer, last_hs;
  logic [TAPS*WEIGHT_W-1:0]   w_row;
  logic signed [ACC_W-1:0]    dot_sum;

  assign in_range = (int'(wt_ch) < NUM_CH) && (int'(wt_idx) < TAPS);
  assign accept   = win_valid && (state_q == IDLE);
  assign wr_ok    = wt_we && in_range && (state_q == IDLE);
  // A write landing with a window accept is parked until that window finishes,
  // so the accepted window still sees the old coefficient.
  assign wr_now   = wr_ok && !accept;
  assign wr_defer = wr_ok && accept;
  assign last_hs  = (state_q == OUT) && out_ready && out_last_q;

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_row
    assign w_row[gi*WEIGHT_W +: WEIGHT_W] = weights_q[ch_q][gi];
  end

  conv_dot_k #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .K        (K),
    .ACC_W    (ACC_W)
  ) u_dot (
    .win  (win_q),
    .wrow (w_row),
    .sum  (dot_sum)
  );

  always_comb begin
    weights_d = weights_q;
    if (wr_now) weights_d[wt_ch][wt_idx] = wt_data;
    if (last_hs && pend_q) weights_d[pend_ch_q][pend_idx_q] = pend_data_q;
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    win_d       = win_q;
    relu_d      = relu_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    wt_err_d    = wt_we && !wr_ok;
    pend_d      = pend_q;
    pend_ch_d   = pend_ch_q;
    pend_idx_d  = pend_idx_q;
    pend_data_d = pend_data_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          win_d   = win_data;
          relu_d  = relu_en;
          ch_d    = '0;
          state_d = CALC;
          if (wr_defer) begin
            pend_d      = 1'b1;
            pend_ch_d   = wt_ch;
            pend_idx_d  = wt_idx;
            pend_data_d = wt_data;
          end
        end
      end
      CALC: begin
        out_data_d  = (relu_q && dot_sum[ACC_W-1]) ? '0 : dot_sum;
        out_ch_d    = ch_q;
        out_last_d  = (ch_q == CH_W'(NUM_CH - 1));
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = CALC;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      win_q       <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      wt_err_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_ch_q   <= '0;
      pend_idx_q  <= '0;
      pend_data_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          weights_q[c][t] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      win_q       <= win_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      wt_err_q    <= wt_err_d;
      pend_q      <= pend_d;
      pend_ch_q   <= pend_ch_d;
      pend_idx_q  <= pend_idx_d;
      pend_data_q <= pend_data_d;
      weights_q   <= weights_d;
    end
  end

  assign win_ready = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign wt_err    = wt_err_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: weight model plus result scoreboard queue.
module tb_conv_mac_engine;

  localparam int DW  = 32;
  localparam int KK  = 25;
  localparam int NCH = 8;
  localparam int AW  = 69;

  logic               clk;
  logic               rst;
  logic               wt_we;
  logic [2:0]         wt_ch;
  logic [4:0]         wt_idx;
  logic signed [31:0] wt_data;
  logic               wt_err;
  logic               win_valid;
  logic               win_ready;
  logic [KK*DW-1:0]   win_data;
  logic               relu_en;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_ch;
  logic               out_last;
  logic signed [AW-1:0] out_data;

  conv_mac_engine dut (
    .clk       (clk),
    .rst       (rst),
    .wt_we     (wt_we),
    .wt_ch     (wt_ch),
    .wt_idx    (wt_idx),
    .wt_data   (wt_data),
    .wt_err    (wt_err),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0]    ch;
    logic          last;
    logic [AW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  logic signed [31:0] wm [NCH][KK];

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [AW-1:0] model(input int ch, input logic signed [31:0] pix,
                                                 input bit relu);
    logic signed [AW-1:0] s, a, b;
    s = '0;
    for (int t = 0; t < KK; t++) begin
      a = pix;
      b = wm[ch][t];
      s = s + a * b;
    end
    if (relu && s < 0) s = '0;
    return s;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < NCH; c++)
      for (int t = 0; t < KK; t++)
        wm[c][t] = '0;
  endtask

  task automatic write_wt(input int ch, input int idx, input logic signed [31:0] d,
                          input bit exp_err);
    @(posedge clk); #1;
    wt_we = 1'b1; wt_ch = 3'(ch); wt_idx = 5'(idx); wt_data = d;
    @(posedge clk); #1;
    wt_we = 1'b0;
    @(negedge clk);
    chk("wt_err", AW'(wt_err), AW'(exp_err));
    if (!exp_err) wm[ch][idx] = d;
  endtask

  task automatic run_window(input logic signed [31:0] pix, input bit relu, input int stall_ch,
                            input int stall_n, input bit bad_wr, input int abort_ch);
    int acc_cyc, n, extra;
    exp_t e;
    extra = (stall_ch >= 0) ? stall_n : 0;
    for (int c = 0; c < NCH; c++) begin
      e.ch = 3'(c); e.last = (c == NCH - 1); e.data = model(c, pix, relu);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    win_valid = 1'b1; relu_en = relu; out_ready = 1'b1;
    for (int t = 0; t < KK; t++) win_data[t*DW +: DW] = pix;
    @(negedge clk);
    chk("win_ready_idle", AW'(win_ready), AW'(1));
    @(posedge clk); #1;
    acc_cyc = cyc;
    win_valid = 1'b0; relu_en = ~relu;
    for (int c = 0; c < NCH; c++) begin
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 8) begin @(negedge clk); n++; end
      if (!out_valid) begin
        chk("out_valid_timeout", AW'(0), AW'(1));
        exp_q.delete();
        return;
      end
      if (c == 0) chk("first_valid_latency", AW'(cyc - acc_cyc), AW'(1));
      e = exp_q.pop_front();
      chk("out_ch", AW'(out_ch), AW'(e.ch));
      chk("out_data", out_data, e.data);
      chk("out_last", AW'(out_last), AW'(e.last));
      chk("win_ready_busy", AW'(win_ready), AW'(0));
      $display("window pix=%0d ch=%0d data=%0d last=%0b", pix, out_ch, out_data, out_last);
      if (c == abort_ch) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", AW'(out_valid), AW'(0));
        chk("rst_out_data", out_data, AW'(0));
        chk("rst_out_ch", AW'(out_ch), AW'(0));
        chk("rst_out_last", AW'(out_last), AW'(0));
        chk("rst_win_ready", AW'(win_ready), AW'(1));
        exp_q.delete();
        clear_model();
        return;
      end
      if (c == stall_ch) begin
        out_ready = 1'b0;
        if (bad_wr) begin
          wt_we = 1'b1; wt_ch = 3'd0; wt_idx = 5'd0; wt_data = 32'sd99;
        end
        for (int i = 0; i < stall_n; i++) begin
          @(negedge clk);
          if (i == 0 && bad_wr) begin
            wt_we = 1'b0;
            chk("wt_err_busy", AW'(wt_err), AW'(1));
          end
          chk("hold_valid", AW'(out_valid), AW'(1));
          chk("hold_ch", AW'(out_ch), AW'(e.ch));
          chk("hold_data", out_data, e.data);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("win_ready_return", AW'(win_ready), AW'(1));
    chk("window_cycles", AW'(cyc - acc_cyc), AW'(2 * NCH + extra));
    chk("idle_out_valid", AW'(out_valid), AW'(0));
  endtask

  initial begin
    rst = 1'b1; wt_we = 1'b0; wt_ch = '0; wt_idx = '0; wt_data = '0;
    win_valid = 1'b0; win_data = '0; relu_en = 1'b0; out_ready = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", AW'(out_valid), AW'(0));
    chk("reset_out_data", out_data, AW'(0));
    chk("reset_out_ch", AW'(out_ch), AW'(0));
    chk("reset_out_last", AW'(out_last), AW'(0));
    chk("reset_wt_err", AW'(wt_err), AW'(0));
    chk("reset_win_ready", AW'(win_ready), AW'(1));

    for (int t = 0; t < KK; t++) write_wt(0, t, 32'sd1, 1'b0);
    write_wt(1, 12, -32'sd3, 1'b0);
    for (int t = 0; t < KK; t++) write_wt(2, t, -32'sd2, 1'b0);

    run_window(32'sd1, 1'b0, -1, 0, 1'b0, -1);
    run_window(32'sd1, 1'b1, -1, 0, 1'b0, -1);

    for (int t = 0; t < KK; t++) write_wt(0, t, 32'sh80000000, 1'b0);
    run_window(32'sh80000000, 1'b0, -1, 0, 1'b0, -1);

    run_window(32'sd3, 1'b0, 3, 5, 1'b1, -1);
    run_window(32'sd2, 1'b0, -1, 0, 1'b0, -1);

    write_wt(0, 25, 32'sd5, 1'b1);

    run_window(32'sd1, 1'b0, -1, 0, 1'b0, 4);
    run_window(32'sd7, 1'b0, -1, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
